rng_stream_ctrl: RTL

RNG_STREAM_CTRL -- requirements
Module: rng_stream_ctrl

---
 rtl/rng_stream_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/rng_stream_ctrl.sv
// rng_stream_ctrl: command-driven gate between an LFSR byte source and a UART
// transmitter. UART commands select between idle, continuous streaming and
// counted bursts. Accepted random bytes are buffered in a small FIFO that
// drains to the transmitter whenever it is free.
//
// Optional feature: define RNG_STREAM_CTRL_DROP_COUNT_EN to enable a
// saturating counter of words lost to a full FIFO. Without the macro,
// drop_count is tied to zero and no counter logic is built.
module rng_stream_ctrl #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_valid,
    input  logic [7:0]            word,
    input  logic                  word_valid,
    input  logic                  tx_busy,
    output logic                  tx_start,
    output logic [7:0]            tx_byte,
    output logic [1:0]            mode,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic [7:0]            drop_count
);

    localparam int                  DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_STEP = (DEPTH_LOG2)'(1);
    localparam logic [DEPTH_LOG2:0] LEVEL_STEP = (DEPTH_LOG2 + 1)'(1);

    localparam logic [7:0] CMD_STREAM = 8'h73;
    localparam logic [7:0] CMD_STOP   = 8'h70;
    localparam logic [7:0] CMD_BURST  = 8'h6E;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        ARG    = 2'd2,
        BURST  = 2'd3
    } state_t;

    state_t                mode_q, mode_d;
    logic [8:0]            remaining_q, remaining_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  tx_start_q, tx_start_d;
    logic [7:0]            tx_byte_q, tx_byte_d;
    logic [7:0]            mem_q [DEPTH];

    logic fifo_full;
    logic fifo_empty;
    logic pop;
    logic word_offered;
    logic push;

    // Decide whether this cycle's random word is wanted (judged on the current
    // mode) and whether the FIFO can take it; a pending pop frees a slot.
    always_comb begin
        fifo_full    = (level_q == FULL_LEVEL);
        fifo_empty   = (level_q == '0);
        pop          = tx_start_q;
        word_offered = word_valid &&
                       ((mode_q == STREAM) || ((mode_q == BURST) && (remaining_q != 9'd0)));
        push         = word_offered && (!fifo_full || pop);
    end

    // Mode sequencing: burst countdown first, then any accepted command overrides it.
    always_comb begin
        mode_d      = mode_q;
        remaining_d = remaining_q;
        if ((mode_q == BURST) && push) begin
            remaining_d = remaining_q - 9'd1;
        end
        if ((mode_q == BURST) && (remaining_d == 9'd0)) begin
            mode_d = IDLE;
        end
        if (rx_valid) begin
            if (mode_q == ARG) begin
                mode_d      = BURST;
                remaining_d = (rx_byte == 8'h00) ? 9'd256 : {1'b0, rx_byte};
            end else begin
                case (rx_byte)
                    CMD_STREAM: begin
                        mode_d      = STREAM;
                        remaining_d = 9'd0;
                    end
                    CMD_STOP: begin
                        mode_d      = IDLE;
                        remaining_d = 9'd0;
                    end
                    CMD_BURST: begin
                        mode_d      = ARG;
                        remaining_d = 9'd0;
                    end
                    default: begin
                        mode_d      = mode_q;
                    end
                endcase
            end
        end
    end

    // FIFO bookkeeping and the transmit handshake; a byte leaves on the cycle tx_start is high.
    always_comb begin
        wr_ptr_d = push ? (wr_ptr_q + PTR_STEP) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_STEP) : rd_ptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LEVEL_STEP;
            2'b01:   level_d = level_q - LEVEL_STEP;
            default: level_d = level_q;
        endcase
        tx_start_d = !fifo_empty && !tx_busy && !tx_start_q;
        tx_byte_d  = tx_start_d ? mem_q[rd_ptr_q] : tx_byte_q;
    end

    // All control state, cleared asynchronously so reset discards queued bytes and counts.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            mode_q      <= IDLE;
            remaining_q <= 9'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            tx_start_q  <= 1'b0;
            tx_byte_q   <= 8'h00;
        end else begin
            mode_q      <= mode_d;
            remaining_q <= remaining_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            tx_start_q  <= tx_start_d;
            tx_byte_q   <= tx_byte_d;
        end
    end

    // FIFO storage needs no reset; the pointers and level define what is valid.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= word;
        end
    end

`ifdef RNG_STREAM_CTRL_DROP_COUNT_EN
    logic       drop;
    logic [7:0] drop_count_q, drop_count_d;

    assign drop = word_offered && fifo_full && !pop;

    // Count words lost to a full FIFO, holding at 255.
    always_comb begin
        drop_count_d = drop_count_q;
        if (drop && (drop_count_q != 8'hFF)) begin
            drop_count_d = drop_count_q + 8'd1;
        end
    end

    // Drop counter register, cleared only by reset.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            drop_count_q <= 8'h00;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;
`else
    assign drop_count = 8'h00;
`endif

    assign tx_start   = tx_start_q;
    assign tx_byte    = tx_byte_q;
    assign mode       = mode_q;
    assign fifo_level = level_q;

endmodule
